gpio_irq: RTL and testbench
===========================

GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the number of IO pins (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the input synchroniser depth (2..4).
REQ-003 SHALL have port i_Clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port i_Addr, input, 3, the register select.
REQ-006 SHALL have port i_WE, input, 1, the write strobe for the register at i_Addr.
REQ-007 SHALL have port i_WD, input, WIDTH, the write data.
REQ-008 SHALL have port o_RD, output, WIDTH, the read data for the register at i_Addr.
REQ-009 SHALL have port IO, inout, WIDTH, the pins.
REQ-010 SHALL have port o_IRQ, output, 1, the registered interrupt request.

Function
REQ-011 The register map SHALL be: 0 DOUT (RW); 1 DDIR (RW); 2 DIN (RO); 3 IE (RW); 4 RISE (RW); 5 FALL (RW); 6 IFLAG (RW, write-1-to-clear); 7 TOGGLE (WO, DOUT <= DOUT ^ i_WD, reads 0).
REQ-012 Writes to address 2 SHALL be ignored.
REQ-013 o_RD SHALL be combinational from i_Addr and the register contents, with no read side effects.
REQ-014 Pin n SHALL drive DOUT[n] when DDIR[n]=1 and SHALL be high-impedance otherwise.
REQ-015 IO SHALL pass through a SYNC_STAGES-deep flop chain; DIN SHALL equal the last stage, so a pin change is visible in DIN SYNC_STAGES cycles later.
REQ-016 PREV SHALL hold DIN delayed by one cycle.
REQ-017 rise = DIN & ~PREV and fall = ~DIN & PREV, evaluated per bit every cycle.
REQ-018 IFLAG[n] SHALL set on the next edge when (rise[n] & RISE[n]) | (fall[n] & FALL[n]), regardless of IE[n] and DDIR[n].
REQ-019 Output pins SHALL be read back through DIN and SHALL raise flags in the same way as inputs.
REQ-020 A write of 1 to IFLAG[n] SHALL clear that bit.
REQ-021 If a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-022 o_IRQ SHALL be registered as |(IFLAG & IE), i.e. it lags IFLAG or IE by one cycle.
REQ-023 A pin edge SHALL therefore reach o_IRQ SYNC_STAGES+2 cycles after it occurs.
REQ-024 Warm-up counter: after reset release, a counter SHALL run SYNC_STAGES+1 cycles, saturating at that value.
REQ-025 While the warm-up counter runs, flag setting SHALL be suppressed, so pins high at reset do not produce spurious rising flags.
REQ-026 Only the low WIDTH bits of each register SHALL exist; there SHALL be no wrap or carry behaviour.

Reset
REQ-027 i_rst_n low SHALL asynchronously clear DOUT, DDIR, IE, RISE, FALL, IFLAG, the sync chain, PREV, the warm-up counter and o_IRQ.
REQ-028 During and after reset all pins SHALL be high-impedance and o_RD SHALL show zero for every register.
REQ-029 Reset asserted mid-operation SHALL abort pending flags and restart warm-up.

Structure
REQ-030 The address constants (ADDR_DOUT..ADDR_TOGGLE) SHALL live in the shared package gpio_pkg.
REQ-031 The synchroniser SHALL be the sub-module gpio_sync, parametrised by WIDTH and SYNC_STAGES.
REQ-032 All other logic SHALL be in gpio_irq.

Verification
REQ-033 Write DDIR=0x0000_00FF, then DOUT=0x0000_00A5 -> IO[7:0]=0xA5, IO[31:8]=Z; write TOGGLE=0x0F -> DOUT reads 0xAA.
REQ-034 Drive IO[31:8]=0x123456 with DDIR=0 -> DIN reads 0x1234_5600 exactly SYNC_STAGES cycles later.
REQ-035 RISE=0x1, IE=0x1, pin0 0->1 -> IFLAG[0]=1 at +3 cycles and o_IRQ=1 at +4; write IFLAG=0x1 -> o_IRQ=0 one cycle later.
REQ-036 FALL=0x2, IE=0, pin1 1->0 -> IFLAG=0x2 and o_IRQ stays 0; then write IE=0x2 -> o_IRQ=1 next cycle.
REQ-037 Pin0 edge flag-set coincides with a W1C of bit0 -> IFLAG[0] remains 1.
REQ-038 Hold IO=0xFFFF_FFFF with RISE=all ones from reset -> IFLAG stays 0 after warm-up; assert i_rst_n=0 mid-run -> all registers read 0 immediately.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt block: register map addresses.
package gpio_pkg;

  localparam logic [2:0] ADDR_DOUT   = 3'd0;
  localparam logic [2:0] ADDR_DDIR   = 3'd1;
  localparam logic [2:0] ADDR_DIN    = 3'd2;
  localparam logic [2:0] ADDR_IE     = 3'd3;
  localparam logic [2:0] ADDR_RISE   = 3'd4;
  localparam logic [2:0] ADDR_FALL   = 3'd5;
  localparam logic [2:0] ADDR_IFLAG  = 3'd6;
  localparam logic [2:0] ADDR_TOGGLE = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop chain bringing asynchronous pin levels into the clock domain.
module gpio_sync #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pins};
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// GPIO block with per-pin direction, edge-detect interrupt flags and a
// registered interrupt request.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_Clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_Addr,
  input  logic             i_WE,
  input  logic [WIDTH-1:0] i_WD,
  output logic [WIDTH-1:0] o_RD,
  inout  wire  [WIDTH-1:0] IO,
  output logic             o_IRQ
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] dout, ddir, din, prev, ie, rise_en, fall_en, iflag;
  logic [WIDTH-1:0] flag_set, flag_clr, iflag_next;
  logic [2:0]       warm;

  for (genvar n = 0; n < WIDTH; n++) begin : g_pin
    assign IO[n] = ddir[n] ? dout[n] : 1'bz;
  end

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (i_Clk),
    .rst_n(i_rst_n),
    .pins (IO),
    .sync (din)
  );

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dout    <= '0;
      ddir    <= '0;
      ie      <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (i_WE) begin
      case (i_Addr)
        ADDR_DOUT:   dout    <= i_WD;
        ADDR_DDIR:   ddir    <= i_WD;
        ADDR_IE:     ie      <= i_WD;
        ADDR_RISE:   rise_en <= i_WD;
        ADDR_FALL:   fall_en <= i_WD;
        ADDR_TOGGLE: dout    <= dout ^ i_WD;
        default:     ;
      endcase
    end
  end

  // Flags stay quiet until the sync chain and PREV hold real pin levels,
  // so pins already high at reset release never look like rising edges.
  always_comb begin
    flag_set   = '0;
    flag_clr   = '0;
    if (warm == WARM_DONE) begin
      flag_set = (din & ~prev & rise_en) | (~din & prev & fall_en);
    end
    if (i_WE && (i_Addr == ADDR_IFLAG)) begin
      flag_clr = i_WD;
    end
    iflag_next = (iflag & ~flag_clr) | flag_set;
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev  <= '0;
      warm  <= '0;
      iflag <= '0;
      o_IRQ <= 1'b0;
    end else begin
      prev  <= din;
      if (warm != WARM_DONE) begin
        warm <= warm + 3'd1;
      end
      iflag <= iflag_next;
      o_IRQ <= |(iflag & ie);
    end
  end

  always_comb begin
    o_RD = '0;
    case (i_Addr)
      ADDR_DOUT:  o_RD = dout;
      ADDR_DDIR:  o_RD = ddir;
      ADDR_DIN:   o_RD = din;
      ADDR_IE:    o_RD = ie;
      ADDR_RISE:  o_RD = rise_en;
      ADDR_FALL:  o_RD = fall_en;
      ADDR_IFLAG: o_RD = iflag;
      default:    o_RD = '0;
    endcase
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Self-checking bench for gpio_irq: register table plus edge/IRQ timing sequences.
module tb_gpio_irq;
  import gpio_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  wire  [31:0] io;
  logic [31:0] tb_drv;
  logic [31:0] tb_en;

  int unsigned n_vec;
  int unsigned n_bad;
  logic [31:0] sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign io[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  gpio_irq #(
    .WIDTH      (32),
    .SYNC_STAGES(2)
  ) dut (
    .i_Clk  (clk),
    .i_rst_n(rst_n),
    .i_Addr (addr),
    .i_WE   (we),
    .i_WD   (wd),
    .o_RD   (rd),
    .IO     (io),
    .o_IRQ  (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a;
    we   = 1'b1;
    wd   = d;
    tick();
    we   = 1'b0;
  endtask

  task automatic chk_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    addr = a;
    sb.push_back(e);
    #1;
    cmp(nm, rd, sb.pop_front());
  endtask

  task automatic chk_irq(input logic e, input string nm);
    sb.push_back({31'b0, e});
    cmp(nm, {31'b0, irq}, sb.pop_front());
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    addr   = '0;
    we     = 1'b0;
    wd     = '0;
    tb_en  = '1;
    tb_drv = '0;

    tbl[0]  = '{1'b1, ADDR_DOUT,   32'hDEADBEEF, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, ADDR_DIN,    32'hFFFFFFFF, 32'h00000000};
    tbl[2]  = '{1'b1, ADDR_IE,     32'h0000FFFF, 32'h0000FFFF};
    tbl[3]  = '{1'b1, ADDR_RISE,   32'h12345678, 32'h12345678};
    tbl[4]  = '{1'b1, ADDR_FALL,   32'h87654321, 32'h87654321};
    tbl[5]  = '{1'b1, ADDR_TOGGLE, 32'hFFFF0000, 32'h00000000};
    tbl[6]  = '{1'b0, ADDR_DOUT,   32'h00000000, 32'h2152BEEF};
    tbl[7]  = '{1'b1, ADDR_IFLAG,  32'hFFFFFFFF, 32'h00000000};
    tbl[8]  = '{1'b0, ADDR_DDIR,   32'h00000000, 32'h00000000};
    tbl[9]  = '{1'b1, ADDR_DOUT,   32'h00000000, 32'h00000000};
    tbl[10] = '{1'b1, ADDR_IE,     32'h00000000, 32'h00000000};
    tbl[11] = '{1'b1, ADDR_RISE,   32'h00000000, 32'h00000000};
    tbl[12] = '{1'b1, ADDR_FALL,   32'h00000000, 32'h00000000};

    tick();
    tick();
    for (int unsigned a = 0; a < 8; a++) begin
      chk_rd(3'(a), 32'h0, $sformatf("reset_rd%0d", a));
    end
    chk_irq(1'b0, "reset_irq");
    rst_n = 1'b1;
    repeat (5) tick();

    foreach (tbl[i]) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wd);
      chk_rd(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // input latency: DIN follows pins exactly two clocks later
    tb_drv = 32'h12345600;
    tick();
    chk_rd(ADDR_DIN, 32'h0, "din_lat1");
    tick();
    chk_rd(ADDR_DIN, 32'h12345600, "din_lat2");

    // low byte as outputs, upper pins still driven by the bench
    tb_en = 32'hFFFFFF00;
    wr(ADDR_DDIR, 32'h000000FF);
    wr(ADDR_DOUT, 32'h000000A5);
    cmp("io_out", {24'h0, io[7:0]}, 32'h000000A5);
    wr(ADDR_TOGGLE, 32'h0000000F);
    chk_rd(ADDR_DOUT, 32'h000000AA, "dout_toggle");
    cmp("io_toggle", {24'h0, io[7:0]}, 32'h000000AA);
    tick();
    tick();
    chk_rd(ADDR_DIN, 32'h123456AA, "din_readback");
    wr(ADDR_DDIR, 32'h0);
    tb_en  = '1;
    tb_drv = '0;
    wr(ADDR_DOUT, 32'h0);
    repeat (4) tick();

    // rising edge on pin0 through to IRQ and W1C
    wr(ADDR_RISE, 32'h1);
    wr(ADDR_IE, 32'h1);
    tb_drv[0] = 1'b1;
    tick();
    tick();
    chk_rd(ADDR_IFLAG, 32'h0, "rise_early");
    tick();
    chk_rd(ADDR_IFLAG, 32'h1, "rise_flag");
    chk_irq(1'b0, "rise_irq_lag");
    tick();
    chk_irq(1'b1, "rise_irq");
    wr(ADDR_IFLAG, 32'h1);
    chk_rd(ADDR_IFLAG, 32'h0, "rise_w1c");
    tick();
    chk_irq(1'b0, "rise_irq_clr");

    // falling edge with IE off, then enable
    wr(ADDR_RISE, 32'h0);
    wr(ADDR_FALL, 32'h2);
    wr(ADDR_IE, 32'h0);
    tb_drv[1] = 1'b1;
    repeat (4) tick();
    tb_drv[1] = 1'b0;
    repeat (3) tick();
    chk_rd(ADDR_IFLAG, 32'h2, "fall_flag");
    tick();
    chk_irq(1'b0, "fall_irq_masked");
    wr(ADDR_IE, 32'h2);
    chk_irq(1'b0, "ie_irq_lag");
    tick();
    chk_irq(1'b1, "ie_irq");
    wr(ADDR_IFLAG, 32'h2);
    wr(ADDR_IE, 32'h0);
    wr(ADDR_FALL, 32'h0);

    // flag set collides with W1C of the same bit
    wr(ADDR_RISE, 32'h1);
    tb_drv[0] = 1'b0;
    repeat (4) tick();
    tb_drv[0] = 1'b1;
    tick();
    tick();
    wr(ADDR_IFLAG, 32'h1);
    chk_rd(ADDR_IFLAG, 32'h1, "set_wins");
    wr(ADDR_IFLAG, 32'h1);
    chk_rd(ADDR_IFLAG, 32'h0, "w1c_after");

    // pending flags, then asynchronous reset mid-run
    wr(ADDR_RISE, 32'hFFFFFFFF);
    tb_drv = '1;
    repeat (4) tick();
    chk_rd(ADDR_IFLAG, 32'hFFFFFFFE, "all_rise");
    wr(ADDR_IE, 32'h0000FFFF);
    tick();
    chk_irq(1'b1, "pre_reset_irq");
    rst_n = 1'b0;
    #1;
    for (int unsigned a = 0; a < 8; a++) begin
      chk_rd(3'(a), 32'h0, $sformatf("midrst_rd%0d", a));
    end
    chk_irq(1'b0, "midrst_irq");
    tick();
    tick();
    rst_n = 1'b1;
    wr(ADDR_RISE, 32'hFFFFFFFF);
    repeat (6) tick();
    chk_rd(ADDR_IFLAG, 32'h0, "warmup_no_flag");
    chk_rd(ADDR_DIN, 32'hFFFFFFFF, "warmup_din");
    chk_irq(1'b0, "warmup_irq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
